// File: rtl/aer_in_event_fifo.sv
// Buffered AER event source: valid/ready ingress into a FIFO with type/range filtering,
// replayed to the LRF mapper over a registered four-phase REQ/ACK handshake.
module aer_in_event_fifo #(
    parameter int AER_WIDTH  = 12,
    parameter int FIFO_DEPTH = 16,
    parameter int FM_C       = 16,
    parameter int FM_W       = 32,
    parameter int FM_H       = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          IN_VALID,
    input  logic [AER_WIDTH-1:0]          IN_EVENT,
    output logic                          IN_READY,
    output logic                          MAP_IN_AERIN_REQ,
    output logic [AER_WIDTH-1:0]          MAP_IN_AERIN_EVENT,
    output logic [AER_WIDTH-3:0]          MAP_IN_AERIN_IDX,
    input  logic                          MAP_IN_AERIN_ACK,
    output logic [$clog2(FIFO_DEPTH):0]   FIFO_COUNT,
    output logic                          FIFO_EMPTY,
    output logic                          FIFO_FULL,
    output logic [7:0]                    DROP_CNT,
    output logic                          RANGE_ERR
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int IW = AER_WIDTH - 2;
    localparam int XB = $clog2(FM_W);
    localparam int YB = $clog2(FM_H);
    localparam int CB = $clog2(FM_C);
    localparam logic [PW:0] DEPTH_L = (PW+1)'(FIFO_DEPTH);
    localparam logic [XB:0] FM_W_L  = (XB+1)'(FM_W);
    localparam logic [YB:0] FM_H_L  = (YB+1)'(FM_H);
    localparam logic [CB:0] FM_C_L  = (CB+1)'(FM_C);

    typedef enum logic [1:0] {S_IDLE, S_REQ_HI, S_ACK_LO} state_t;

    logic [AER_WIDTH-1:0] mem_q [FIFO_DEPTH];
    logic [PW-1:0]        wr_q, rd_q;
    logic [PW:0]          cnt_q;
    state_t               state_q, state_d;
    logic [AER_WIDTH-1:0] ev_q, ev_d;
    logic [7:0]           drop_q;
    logic                 rerr_q;

    logic [1:0]    ev_type;
    logic [XB-1:0] x;
    logic [YB-1:0] y;
    logic [CB-1:0] c;
    logic          oor, accept, range_drop, drop, store, pop;

    // Shifts rather than slices keep field extraction legal for any parameter mix.
    assign ev_type    = IN_EVENT[AER_WIDTH-1:AER_WIDTH-2];
    assign x          = XB'(IN_EVENT[IW-1:0]);
    assign y          = YB'(IN_EVENT[IW-1:0] >> XB);
    assign c          = CB'(IN_EVENT[IW-1:0] >> (XB + YB));
    assign oor        = ({1'b0, x} >= FM_W_L) || ({1'b0, y} >= FM_H_L) || ({1'b0, c} >= FM_C_L);
    assign accept     = IN_VALID & IN_READY;
    assign range_drop = accept & (ev_type == 2'b00) & oor;
    assign drop       = range_drop | (accept & (ev_type == 2'b11));
    assign store      = accept & ~drop;
    assign pop        = (state_q == S_REQ_HI) & MAP_IN_AERIN_ACK;

    assign FIFO_COUNT         = cnt_q;
    assign FIFO_EMPTY         = (cnt_q == '0);
    assign FIFO_FULL          = (cnt_q == DEPTH_L);
    assign IN_READY           = ~FIFO_FULL;
    assign MAP_IN_AERIN_REQ   = (state_q == S_REQ_HI);
    assign MAP_IN_AERIN_EVENT = ev_q;
    assign MAP_IN_AERIN_IDX   = ev_q[IW-1:0];
    assign DROP_CNT           = drop_q;
    assign RANGE_ERR          = rerr_q;

    always_ff @(posedge clk) begin
        if (store) mem_q[wr_q] <= IN_EVENT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q    <= '0;
            rd_q    <= '0;
            cnt_q   <= '0;
            state_q <= S_IDLE;
            ev_q    <= '0;
            drop_q  <= '0;
            rerr_q  <= 1'b0;
        end else begin
            if (store) wr_q <= wr_q + PW'(1);
            if (pop)   rd_q <= rd_q + PW'(1);
            case ({store, pop})
                2'b10:   cnt_q <= cnt_q + (PW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (PW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
            if (drop && drop_q != 8'hFF) drop_q <= drop_q + 8'd1;
            if (range_drop) rerr_q <= 1'b1;
            state_q <= state_d;
            ev_q    <= ev_d;
        end
    end

    // Head entry is latched only on entry to REQ_HI so EVENT is stable for the whole handshake.
    always_comb begin
        state_d = state_q;
        ev_d    = ev_q;
        case (state_q)
            S_IDLE: begin
                if (!FIFO_EMPTY) begin
                    ev_d    = mem_q[rd_q];
                    state_d = S_REQ_HI;
                end
            end
            S_REQ_HI: begin
                if (MAP_IN_AERIN_ACK) state_d = S_ACK_LO;
            end
            S_ACK_LO: begin
                if (!MAP_IN_AERIN_ACK) begin
                    if (!FIFO_EMPTY) begin
                        ev_d    = mem_q[rd_q];
                        state_d = S_REQ_HI;
                    end else begin
                        state_d = S_IDLE;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end
endmodule
